// File: rtl/snitch_ssr_credit_sink_pkg.sv
// Shared defaults and index helpers for the SSR credit sink.
// No logic of its own; used at elaboration time only.
// Pointer helpers handle non-power-of-two depths by explicit wrap.
package snitch_ssr_credit_sink_pkg;

  localparam int unsigned DefaultDepth     = 4;
  localparam int unsigned DefaultDataWidth = 64;

  // Index width for a buffer of the given depth; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Advance a circular index, wrapping from depth-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/snitch_ssr_credit_sink_mem.sv
// Depth x DataWidth register array with one write port and one async read port.
// Write takes effect on the next clock edge; read is combinational.
// No flow control: the caller decides when to write.
module snitch_ssr_credit_sink_mem #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  // Payload storage is deliberately not reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/snitch_ssr_credit_sink.sv
// Credit-flow receive buffer: stores credited pushes, drains on valid/ready, returns credits.
// Push visible 1 cycle later (no fall-through); credit pulse 1 cycle after each pop.
// Input has no ready (sender holds credit); pushes into a full buffer are dropped and flagged.
module snitch_ssr_credit_sink
  import snitch_ssr_credit_sink_pkg::*;
#(
  parameter int unsigned Depth            = DefaultDepth,
  parameter int unsigned DataWidth        = DefaultDataWidth,
  parameter bit          AssertNoOverflow = 1'b1,
  parameter type         usage_t          = logic [$clog2(Depth):0]
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 credit_give_o,
  output usage_t               usage_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrWidth = idx_width(Depth);
  typedef logic [PtrWidth-1:0] ptr_t;
  localparam usage_t DepthUsage = usage_t'(Depth);

  ptr_t   wptr_q, rptr_q;
  usage_t count_q;
  logic   credit_q, overflow_q;
  logic   full, push, pop, overflow_evt;

  assign full        = (count_q == DepthUsage);
  assign out_valid_o = (count_q != '0);
  // Flush wins over everything: a handshake in the flush cycle is discarded.
  assign pop          = out_valid_o && out_ready_i && !flush_i;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign push         = in_valid_i && (!full || pop) && !flush_i;
  assign overflow_evt = in_valid_i && full && !out_ready_i && !flush_i;

  snitch_ssr_credit_sink_mem #(
    .Depth    (Depth),
    .DataWidth(DataWidth),
    .AddrWidth(PtrWidth)
  ) i_mem (
    .clk_i  (clk_i),
    .we_i   (push),
    .waddr_i(wptr_q),
    .wdata_i(in_data_i),
    .raddr_i(rptr_q),
    .rdata_o(out_data_o)
  );

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_t'(wrap_inc(32'(wptr_q), Depth));
      if (pop)  rptr_q <= ptr_t'(wrap_inc(32'(rptr_q), Depth));
      case ({push, pop})
        2'b10:   count_q <= count_q + usage_t'(1);
        2'b01:   count_q <= count_q - usage_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // One registered credit pulse per pop, plus the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      credit_q <= pop;
      if (overflow_evt) overflow_q <= 1'b1;
    end
  end

  assign credit_give_o = credit_q;
  assign usage_o       = count_q;
  assign overflow_o    = overflow_q;

  // A correctly credited sender can never push into a full buffer.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(AssertNoOverflow && overflow_evt))
    else $error("credit sink: push while full");

  // A stalled head must hold its payload.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_data_o)))
    else $error("credit sink: head changed while stalled");

  // Occupancy is bounded by the buffer size.
  assert property (@(posedge clk_i) disable iff (!rst_ni) (usage_o <= DepthUsage))
    else $error("credit sink: usage above depth");

endmodule

// File: tb/tb_snitch_ssr_credit_sink.sv
module tb_snitch_ssr_credit_sink;

  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;

  // Depth-4 instance for directed checks (overflow deliberately provoked).
  logic          flush4 = 1'b0, vld4 = 1'b0, rdy4 = 1'b0;
  logic [DW-1:0] dat4 = '0;
  logic          ovld4, cg4, ovf4;
  logic [DW-1:0] odat4;
  logic [2:0]    use4;

  // Depth-3 instance for the closed loop with a credit-counting sender.
  logic          flush3 = 1'b0, vld3 = 1'b0, rdy3 = 1'b0;
  logic [DW-1:0] dat3 = '0;
  logic          ovld3, cg3, ovf3;
  logic [DW-1:0] odat3;
  logic [2:0]    use3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  snitch_ssr_credit_sink #(.Depth(4), .DataWidth(DW), .AssertNoOverflow(1'b0)) u4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush4),
    .in_valid_i(vld4), .in_data_i(dat4),
    .out_valid_o(ovld4), .out_ready_i(rdy4), .out_data_o(odat4),
    .credit_give_o(cg4), .usage_o(use4), .overflow_o(ovf4)
  );

  snitch_ssr_credit_sink #(.Depth(3), .DataWidth(DW)) u3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush3),
    .in_valid_i(vld3), .in_data_i(dat3),
    .out_valid_o(ovld3), .out_ready_i(rdy3), .out_data_o(odat3),
    .credit_give_o(cg3), .usage_o(use3), .overflow_o(ovf3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic outs4(input string tag, input logic v, input logic [2:0] u,
                       input logic c, input logic o);
    check({tag, ".valid"},    64'(ovld4), 64'(v));
    check({tag, ".usage"},    64'(use4),  64'(u));
    check({tag, ".credit"},   64'(cg4),   64'(c));
    check({tag, ".overflow"}, 64'(ovf4),  64'(o));
  endtask

  initial begin
    int          credits;
    logic        send, cg_prev, popped;
    logic [DW-1:0] exp_d, seq;
    logic [DW-1:0] q[$];

    // Reset, then idle.
    #3;
    outs4("in_reset", 1'b0, 3'd0, 1'b0, 1'b0);
    #9 rst_ni = 1'b1;
    tick();
    outs4("after_reset", 1'b0, 3'd0, 1'b0, 1'b0);
    tick(); tick();
    outs4("idle2", 1'b0, 3'd0, 1'b0, 1'b0);

    // Fill with ready low.
    vld4 = 1'b1; dat4 = 16'hA; tick();
    outs4("push1", 1'b1, 3'd1, 1'b0, 1'b0);
    check("push1.data", 64'(odat4), 64'hA);
    dat4 = 16'hB; tick();
    dat4 = 16'hC; tick();
    dat4 = 16'hD; tick();
    outs4("full", 1'b1, 3'd4, 1'b0, 1'b0);
    check("full.head", 64'(odat4), 64'hA);

    // Overflow: dropped, sticky.
    dat4 = 16'hE; tick();
    outs4("ovf", 1'b1, 3'd4, 1'b0, 1'b1);
    vld4 = 1'b0; tick();
    outs4("ovf_sticky", 1'b1, 3'd4, 1'b0, 1'b1);

    // Drain in order; one credit one cycle after each pop.
    rdy4 = 1'b1;
    check("drain0.data", 64'(odat4), 64'hA); tick();
    check("drain0.credit", 64'(cg4), 64'd1);
    check("drain1.data", 64'(odat4), 64'hB); tick();
    check("drain1.credit", 64'(cg4), 64'd1);
    check("drain2.data", 64'(odat4), 64'hC); tick();
    check("drain2.credit", 64'(cg4), 64'd1);
    check("drain3.data", 64'(odat4), 64'hD); tick();
    outs4("drained", 1'b0, 3'd0, 1'b1, 1'b1);
    rdy4 = 1'b0; tick();
    outs4("drained_idle", 1'b0, 3'd0, 1'b0, 1'b1);

    // Flush clears the overflow flag.
    flush4 = 1'b1; tick(); flush4 = 1'b0;
    outs4("flush_clr", 1'b0, 3'd0, 1'b0, 1'b0);

    // Simultaneous push/pop at count 2.
    vld4 = 1'b1; dat4 = 16'h1; tick();
    dat4 = 16'h2; tick();
    rdy4 = 1'b1; dat4 = 16'h3; tick();
    outs4("pp2", 1'b1, 3'd2, 1'b1, 1'b0);
    check("pp2.head", 64'(odat4), 64'h2);

    // Fill to 4 and repeat at full: no overflow.
    rdy4 = 1'b0; dat4 = 16'h4; tick();
    dat4 = 16'h5; tick();
    outs4("refill", 1'b1, 3'd4, 1'b0, 1'b0);
    rdy4 = 1'b1; dat4 = 16'h6; tick();
    outs4("pp4", 1'b1, 3'd4, 1'b1, 1'b0);
    check("pp4.head", 64'(odat4), 64'h3);

    // Down to 3, then flush with a push and a pop in the same cycle.
    vld4 = 1'b0; tick();
    outs4("at3", 1'b1, 3'd3, 1'b1, 1'b0);
    check("at3.head", 64'(odat4), 64'h4);
    flush4 = 1'b1; vld4 = 1'b1; dat4 = 16'h9; tick();
    flush4 = 1'b0; vld4 = 1'b0; rdy4 = 1'b0;
    outs4("flush_mid", 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    outs4("flush_nocredit", 1'b0, 3'd0, 1'b0, 1'b0);

    // Pointers restart after flush.
    vld4 = 1'b1; dat4 = 16'h7; tick(); vld4 = 1'b0;
    outs4("post_flush", 1'b1, 3'd1, 1'b0, 1'b0);
    check("post_flush.data", 64'(odat4), 64'h7);

    // Asynchronous reset with a pop pending: immediate clear, no credit.
    rdy4 = 1'b1;
    rst_ni = 1'b0; #1;
    outs4("arst", 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    outs4("arst_nocredit", 1'b0, 3'd0, 1'b0, 1'b0);
    rdy4 = 1'b0;
    rst_ni = 1'b1;
    tick();

    // Closed loop: Depth=3 sink against a 3-credit sender.
    credits = 3;
    seq = 16'h100;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      vld3 = ($urandom_range(0, 1) == 1) && (credits > 0);
      rdy3 = ($urandom_range(0, 1) == 1);
      dat3 = seq;
      send    = vld3;
      cg_prev = cg3;
      popped  = ovld3 && rdy3;
      if (popped) begin
        exp_d = (q.size() > 0) ? q[0] : 16'hFFFF;
        check("loop.order", 64'(odat3), 64'(exp_d));
        if (q.size() > 0) void'(q.pop_front());
      end
      if (send) begin
        q.push_back(seq);
        seq = seq + 16'd1;
      end
      tick();
      credits = credits - int'(send) + int'(cg_prev);
      check("loop.underflow", 64'(credits < 0), 64'd0);
      check("loop.conserve", 64'(credits + int'(use3) + int'(cg3)), 64'd3);
    end
    vld3 = 1'b0; rdy3 = 1'b0;
    check("loop.no_overflow", 64'(ovf3), 64'd0);
    check("loop.usage_match", 64'(use3), 64'(q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
